obstacle_mem_reader: RTL
========================

# obstacle_mem_reader

Avalon-MM read initiator for the obstacle on-chip memory, a 1024 x 32 single-port RAM with a fixed read latency of 1 and no waitrequest. On a start pulse it reads a contiguous, wrap-around range of words from that memory. It buffers the returned words in a small FIFO and presents them as a valid/ready stream with a last marker. The block sits between the obstacle memory's slave port and the obstacle rendering/collision logic, and never writes the memory.

## Interface
- ADDR_W, 10, word-address width of the obstacle memory.
- DATA_W, 32, data word width.
- FIFO_DEPTH, 4, output buffer depth in words; power of two, minimum 2.
- clk  in  1  single clock for all logic.
- reset  in  1  synchronous, active-high reset; sampled on the rising edge of clk.
- start  in  1  one-cycle request to begin a scan; sampled only in IDLE.
- base_addr  in  ADDR_W  first word address of the scan.
- count  in  ADDR_W+1  number of words to read, 0..1024.
- busy  out  1  high in RUN and DRAIN.
- done  out  1  one-cycle pulse when a scan completes.
- avm_address  out  ADDR_W  read address.
- avm_chipselect  out  1  read strobe; high only in a cycle that issues a read.
- avm_write  out  1  tied 0.
- avm_byteenable  out  4  tied 4'hF.
- avm_clken  out  1  tied 1.
- avm_readdata  in  DATA_W  memory data, valid exactly one cycle after a chipselect cycle.
- out_data  out  DATA_W  head-of-FIFO word.
- out_valid  out  1  out_data is valid.
- out_ready  in  1  consumer accepts the word when out_valid & out_ready.
- out_last  out  1  high with the final word of the scan.

## Operation
- States: IDLE, RUN, DRAIN.
- IDLE:
  - start & count!=0: latch base_addr into addr_ptr and count into remaining; clear issued count; go to RUN.
  - start & count==0: stay in IDLE and pulse done on the next cycle; no reads are issued.
- RUN:
  - A read issues in a cycle when issued < count_latched and fifo_level + inflight < FIFO_DEPTH. A word accepted in the same cycle does not add credit.
  - Each issue drives avm_chipselect=1 with avm_address=addr_ptr, then increments addr_ptr modulo 2^ADDR_W (1023 wraps to 0).
  - inflight (0 or 1) marks a read whose data arrives next cycle. That data is pushed into the FIFO unconditionally; credit accounting guarantees space.
  - Go to DRAIN on the cycle the final read issues.
- DRAIN: no reads issue. Go to IDLE once the word with out_last is accepted; done pulses in the following cycle.
- out_last = out_valid & (the head word is word number count_latched of the scan). Track this with a delivered-word counter.
- start is ignored while busy. base_addr and count are ignored except in IDLE.
- Simultaneous FIFO push and pop keeps fifo_level unchanged.
- Pop happens only on out_valid & out_ready.
- FIFO uses registered storage; a word pushed at a clock edge is visible on out_data/out_valid from the next cycle.

## Timing
- Reset values: state IDLE, busy 0, done 0, avm_chipselect 0, avm_address 0, out_valid 0, out_last 0, out_data 0, FIFO empty, inflight 0.
- Reset mid-scan: the block aborts on the next edge and flushes the FIFO. done does not pulse, and data returning for an outstanding read is discarded.
- start sampled at edge E0:
  - first chipselect in cycle 1;
  - readdata returns in cycle 2 and is pushed at the end of cycle 2;
  - out_valid rises in cycle 3.
- With out_ready held high:
  - one read issues and one word is delivered per cycle;
  - word k (1-based) is delivered in cycle k+2;
  - done pulses in cycle N+3;
  - busy is high in cycles 1..N+2.
- Under backpressure, reads stall once fifo_level + inflight reaches FIFO_DEPTH, and resume the cycle after a pop frees credit.

## Test plan
- Memory model returns mem[a] = 32'hA000_0000 | a, one cycle after chipselect. base=0, count=4, out_ready=1 -> chipselect in cycles 1-4 on addresses 0,1,2,3; out_data A0000000..A0000003 in cycles 3-6 with out_last in cycle 6; done in cycle 7.
- Wrap: base=1022, count=4 -> addresses 1022,1023,0,1; data in that order; out_last on A0000001.
- Backpressure: base=16, count=10, out_ready=0 for 12 cycles then 1 -> exactly 4 chipselects before release, no data lost or duplicated, all 10 words in order, out_last only on word 10.
- count=0 start -> no chipselect, busy stays 0, done pulses in cycle 1.
- A second start pulsed during RUN is ignored. reset asserted in cycle 3 of a count=8 scan -> all outputs at reset values the next cycle, no done pulse, and a new start then behaves as in the first scenario.
- count=1024, base=5 -> all 1024 addresses read once, ending at 4; 1024 words delivered in order; done pulses exactly once.

Source files
------------

// File: rtl/obstacle_mem_reader_if.sv
// Bus bundle between the obstacle memory reader, the obstacle on-chip RAM
// and the downstream consumer.
//   master : reader side (drives the Avalon-MM read strobe/address and the
//            output stream; receives readdata and out_ready)
//   slave  : memory/consumer side (returns readdata, drives out_ready)
// Signals:
//   avm_address, avm_chipselect, avm_write, avm_byteenable, avm_clken,
//   avm_readdata                     - Avalon-MM read port of the RAM
//   out_data, out_valid, out_last,
//   out_ready                        - valid/ready word stream
interface obstacle_mem_reader_if #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0] avm_address;
  logic              avm_chipselect;
  logic              avm_write;
  logic [3:0]        avm_byteenable;
  logic              avm_clken;
  logic [DATA_W-1:0] avm_readdata;

  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_last;
  logic              out_ready;

  modport master (
    output avm_address, avm_chipselect, avm_write, avm_byteenable, avm_clken,
    input  avm_readdata,
    output out_data, out_valid, out_last,
    input  out_ready
  );

  modport slave (
    input  avm_address, avm_chipselect, avm_write, avm_byteenable, avm_clken,
    output avm_readdata,
    input  out_data, out_valid, out_last,
    output out_ready
  );
endinterface

// File: rtl/obstacle_mem_reader.sv
// Read initiator for the obstacle on-chip RAM (latency 1, no waitrequest).
// A start pulse scans count words from base_addr upward, wrapping at the top
// of the address space, and streams them out through a small FIFO with a
// last marker on the final word.
// Ports:
//   clk, reset  - single clock, synchronous active-high reset
//   start       - begin a scan (only looked at while idle)
//   base_addr   - first word address of the scan
//   count       - number of words, 0..2^ADDR_W
//   busy        - scan in progress
//   done        - one-cycle completion pulse
//   bus         - Avalon-MM read port and output stream (master modport)
//
// state | meaning
// IDLE  | waiting for start; FIFO empty
// RUN   | issuing reads as FIFO credit allows
// DRAIN | all reads issued; waiting for the last word to be accepted
module obstacle_mem_reader #(
  parameter int ADDR_W     = 10,
  parameter int DATA_W     = 32,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   count,
  output logic              busy,
  output logic              done,
  obstacle_mem_reader_if.master bus
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam int CNT_W = ADDR_W + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [ADDR_W-1:0] addr_ptr;
  logic [CNT_W-1:0]  remaining;     // reads still to issue
  logic [CNT_W-1:0]  deliver_left;  // words still to hand downstream
  logic              inflight;      // read data arrives this coming cycle

  logic [DATA_W-1:0] fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [LVL_W-1:0]  level;

  logic issue;
  logic push;
  logic pop;
  logic valid_w;
  logic last_w;
  logic credit_ok;

  assign valid_w = (level != '0);
  // Head word is the final one of the scan when exactly one is left to deliver.
  assign last_w  = valid_w && (deliver_left == CNT_W'(1));
  assign pop     = valid_w && bus.out_ready;
  assign push    = inflight;
  // Credit uses the registered level only: a pop this cycle frees space
  // for the next cycle, not this one.
  assign credit_ok = (level + LVL_W'(inflight)) < LVL_W'(FIFO_DEPTH);

  assign busy               = (state_q != IDLE);
  assign bus.avm_address    = addr_ptr;
  assign bus.avm_chipselect = issue;
  assign bus.avm_write      = 1'b0;
  assign bus.avm_byteenable = 4'hF;
  assign bus.avm_clken      = 1'b1;
  assign bus.out_valid      = valid_w;
  assign bus.out_last       = last_w;
  assign bus.out_data       = valid_w ? fifo_mem[rd_ptr] : '0;

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    issue   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start && (count != '0)) state_d = RUN;
      end
      RUN: begin
        if ((remaining != '0) && credit_ok) begin
          issue = 1'b1;
          if (remaining == CNT_W'(1)) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (pop && last_w) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      addr_ptr     <= '0;
      remaining    <= '0;
      deliver_left <= '0;
      inflight     <= 1'b0;
      done         <= 1'b0;
    end else begin
      inflight <= issue;
      done     <= ((state_q == IDLE) && start && (count == '0)) ||
                  ((state_q == DRAIN) && pop && last_w);
      if ((state_q == IDLE) && start && (count != '0)) begin
        addr_ptr     <= base_addr;
        remaining    <= count;
        deliver_left <= count;
      end
      if (issue) begin
        addr_ptr  <= addr_ptr + ADDR_W'(1);
        remaining <= remaining - CNT_W'(1);
      end
      if (pop) deliver_left <= deliver_left - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   level <= level + LVL_W'(1);
        2'b01:   level <= level - LVL_W'(1);
        default: ;
      endcase
    end
  end

  // Storage needs no reset; level gates visibility of stale entries.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= bus.avm_readdata;
  end

endmodule
